// File: rtl/trig_velocity_unit.sv
// trig_velocity_unit: three-stage angle-to-velocity generator.
// Turns an angle index and an unsigned speed into signed per-frame
// displacements dx = speed*cos(theta), dy = speed*sin(theta) with
// FRAC_BITS fractional bits. A quarter-wave table is folded by quadrant.
// Valid/ready handshake; the request tag rides along with the data.
module trig_velocity_unit #(
    parameter int N_ANGLES  = 64,
    parameter int FRAC_BITS = 8,
    parameter int SPEED_W   = 4,
    parameter int TAG_W     = 2,
    parameter int OUT_W     = 16
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(N_ANGLES)-1:0] req_angle,
    input  logic [SPEED_W-1:0]          req_speed,
    input  logic [TAG_W-1:0]            req_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_dx,
    output logic signed [OUT_W-1:0]     out_dy,
    output logic [TAG_W-1:0]            out_tag
);

    localparam int A_W   = $clog2(N_ANGLES);
    localparam int IDX_W = A_W - 1;           // holds 0..Q inclusive
    localparam int Q     = N_ANGLES / 4;
    localparam int MAG_W = FRAC_BITS + 1;     // 1.0 needs one extra bit
    localparam int P_W   = MAG_W + SPEED_W;
    localparam logic [IDX_W-1:0] Q_IDX = IDX_W'(Q);
    localparam longint PI_S = 64'sd3373259426; // pi scaled by 2^30

    if (OUT_W < FRAC_BITS + SPEED_W + 2) begin : g_bad_out_w
        $error("trig_velocity_unit: OUT_W too small for FRAC_BITS+SPEED_W+2");
    end
    if ((N_ANGLES < 8) || ((N_ANGLES & (N_ANGLES - 1)) != 0)) begin : g_bad_n_angles
        $error("trig_velocity_unit: N_ANGLES must be a power of two >= 8");
    end

    // Quarter-wave entry: round-half-up(2^FRAC_BITS * sin(2*pi*k/N_ANGLES)).
    // Evaluated at elaboration with a 2^-30 fixed-point Taylor series, which
    // is far finer than the table resolution. End points are forced exact.
    function automatic logic [MAG_W-1:0] tbl_entry(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        logic [MAG_W-1:0] res;
        if (k <= 0) begin
            res = '0;
        end else if (k >= Q) begin
            res = MAG_W'(64'sd1 <<< FRAC_BITS);
        end else begin
            x    = (PI_S * 64'sd2 * longint'(k)) / longint'(N_ANGLES);
            x2   = (x * x) >>> 6'd30;
            term = x;
            sum  = x;
            for (int n = 1; n <= 12; n++) begin
                term = -(((term * x2) >>> 6'd30) / longint'((2 * n) * (2 * n + 1)));
                sum  = sum + term;
            end
            scaled = ((sum <<< FRAC_BITS) + (64'sd1 <<< 6'd29)) >>> 6'd30;
            if (scaled > (64'sd1 <<< FRAC_BITS)) begin
                scaled = 64'sd1 <<< FRAC_BITS;
            end else begin
                scaled = scaled;
            end
            res = MAG_W'(scaled);
        end
        return res;
    endfunction

    logic [MAG_W-1:0] rom_s [0:Q];
    for (genvar g = 0; g <= Q; g++) begin : g_rom
        assign rom_s[g] = tbl_entry(g);
    end

    // Pipeline state
    logic                   v1_q, v2_q, v3_q;
    logic [IDX_W-1:0]       sin_idx1_q, cos_idx1_q;
    logic                   sin_neg1_q, cos_neg1_q, sin_neg2_q, cos_neg2_q;
    logic [SPEED_W-1:0]     spd1_q, spd2_q;
    logic [TAG_W-1:0]       tag1_q, tag2_q, tag3_q;
    logic [MAG_W-1:0]       sin_mag2_q, cos_mag2_q;
    logic signed [OUT_W-1:0] dx3_q, dy3_q;

    logic                   advance_s;
    logic [1:0]             quad_s;
    logic [IDX_W-1:0]       rem_s, comp_s;
    logic [IDX_W-1:0]       sin_idx1_d, cos_idx1_d;
    logic                   sin_neg1_d, cos_neg1_d;
    logic [P_W-1:0]         prod_sin_s, prod_cos_s;
    logic [OUT_W-1:0]       ext_sin_s, ext_cos_s;
    logic signed [OUT_W-1:0] dx3_d, dy3_d;

    assign advance_s = !v3_q || out_ready;
    assign req_ready = advance_s && Reset_n;

    assign quad_s = req_angle[A_W-1 -: 2];
    assign rem_s  = {1'b0, req_angle[A_W-3:0]};
    assign comp_s = Q_IDX - rem_s;

    // Quadrant fold: pick table indices and result signs for sin and cos.
    always_comb begin
        sin_idx1_d = rem_s;
        cos_idx1_d = comp_s;
        sin_neg1_d = 1'b0;
        cos_neg1_d = 1'b0;
        case (quad_s)
            2'd0: begin
                sin_idx1_d = rem_s;  cos_idx1_d = comp_s;
                sin_neg1_d = 1'b0;   cos_neg1_d = 1'b0;
            end
            2'd1: begin
                sin_idx1_d = comp_s; cos_idx1_d = rem_s;
                sin_neg1_d = 1'b0;   cos_neg1_d = 1'b1;
            end
            2'd2: begin
                sin_idx1_d = rem_s;  cos_idx1_d = comp_s;
                sin_neg1_d = 1'b1;   cos_neg1_d = 1'b1;
            end
            2'd3: begin
                sin_idx1_d = comp_s; cos_idx1_d = rem_s;
                sin_neg1_d = 1'b1;   cos_neg1_d = 1'b0;
            end
            default: begin
                sin_idx1_d = rem_s;  cos_idx1_d = comp_s;
                sin_neg1_d = 1'b0;   cos_neg1_d = 1'b0;
            end
        endcase
    end

    // Stage 1: capture folded indices, signs, speed and tag on accept.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v1_q       <= 1'b0;
            sin_idx1_q <= '0;
            cos_idx1_q <= '0;
            sin_neg1_q <= 1'b0;
            cos_neg1_q <= 1'b0;
            spd1_q     <= '0;
            tag1_q     <= '0;
        end else if (advance_s) begin
            v1_q       <= req_valid;
            sin_idx1_q <= sin_idx1_d;
            cos_idx1_q <= cos_idx1_d;
            sin_neg1_q <= sin_neg1_d;
            cos_neg1_q <= cos_neg1_d;
            spd1_q     <= req_speed;
            tag1_q     <= req_tag;
        end
    end

    // Stage 2: registered table reads for both magnitudes.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v2_q       <= 1'b0;
            sin_mag2_q <= '0;
            cos_mag2_q <= '0;
            sin_neg2_q <= 1'b0;
            cos_neg2_q <= 1'b0;
            spd2_q     <= '0;
            tag2_q     <= '0;
        end else if (advance_s) begin
            v2_q       <= v1_q;
            sin_mag2_q <= rom_s[sin_idx1_q];
            cos_mag2_q <= rom_s[cos_idx1_q];
            sin_neg2_q <= sin_neg1_q;
            cos_neg2_q <= cos_neg1_q;
            spd2_q     <= spd1_q;
            tag2_q     <= tag1_q;
        end
    end

    // Scale by speed, zero-extend, then negate where the fold says so.
    // Negating a zero magnitude gives zero, so no special case is needed.
    always_comb begin
        prod_sin_s = P_W'(sin_mag2_q) * P_W'(spd2_q);
        prod_cos_s = P_W'(cos_mag2_q) * P_W'(spd2_q);
        ext_sin_s  = OUT_W'(prod_sin_s);
        ext_cos_s  = OUT_W'(prod_cos_s);
        if (sin_neg2_q) begin
            dy3_d = signed'({OUT_W{1'b0}} - ext_sin_s);
        end else begin
            dy3_d = signed'(ext_sin_s);
        end
        if (cos_neg2_q) begin
            dx3_d = signed'({OUT_W{1'b0}} - ext_cos_s);
        end else begin
            dx3_d = signed'(ext_cos_s);
        end
    end

    // Stage 3: output register; holds while the consumer stalls.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v3_q   <= 1'b0;
            dx3_q  <= '0;
            dy3_q  <= '0;
            tag3_q <= '0;
        end else if (advance_s) begin
            v3_q   <= v2_q;
            dx3_q  <= dx3_d;
            dy3_q  <= dy3_d;
            tag3_q <= tag2_q;
        end
    end

    assign out_valid = v3_q;
    assign out_dx    = dx3_q;
    assign out_dy    = dy3_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_trig_velocity_unit.sv
// Directed self-checking bench for trig_velocity_unit (default and wide
// parameter sets). Expected values are hand-computed constants or come
// from a floating-point trig model.
module tb_trig_velocity_unit;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [5:0]         req_angle = 6'd0;
    logic [3:0]         req_speed = 4'd0;
    logic [1:0]         req_tag = 2'd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_dx, out_dy;
    logic [1:0]         out_tag;

    logic               w_req_valid = 1'b0;
    logic               w_req_ready;
    logic [7:0]         w_req_angle = 8'd0;
    logic [3:0]         w_req_speed = 4'd0;
    logic [1:0]         w_req_tag = 2'd0;
    logic               w_out_valid;
    logic               w_out_ready = 1'b1;
    logic signed [15:0] w_out_dx, w_out_dy;
    logic [1:0]         w_out_tag;

    int n_vec = 0;
    int n_err = 0;

    trig_velocity_unit dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_speed(req_speed), .req_tag(req_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dx(out_dx), .out_dy(out_dy), .out_tag(out_tag)
    );

    trig_velocity_unit #(.N_ANGLES(256), .FRAC_BITS(10), .SPEED_W(4),
                         .TAG_W(2), .OUT_W(16)) dut_w (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_angle(w_req_angle), .req_speed(w_req_speed), .req_tag(w_req_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_dx(w_out_dx), .out_dy(w_out_dy), .out_tag(w_out_tag)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: round-half-up magnitude of the exact trig value, times speed.
    function automatic void model(input int n, input int f, input int ang, input int spd,
                                  output longint dx, output longint dy);
        real pi, th, c, s;
        longint mc, ms;
        pi = $acos(-1.0);
        th = 2.0 * pi * real'(ang) / real'(n);
        c  = $cos(th);
        s  = $sin(th);
        mc = longint'($floor((2.0 ** f) * ((c < 0.0) ? -c : c) + 0.5));
        ms = longint'($floor((2.0 ** f) * ((s < 0.0) ? -s : s) + 0.5));
        dx = (c < 0.0) ? -(mc * spd) : (mc * spd);
        dy = (s < 0.0) ? -(ms * spd) : (ms * spd);
    endfunction

    // Single request on the default unit; checks latency and result.
    task automatic send_one(input string nm, input int ang, input int spd, input int tg,
                            input longint edx, input longint edy);
        int c;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_angle = 6'(ang);
        req_speed = 4'(spd);
        req_tag   = 2'(tg);
        #1;
        chk({nm, "_rdy"}, longint'(req_ready), 1);
        @(posedge Clk); #1;
        req_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 10) begin
            @(posedge Clk); #1;
            c++;
        end
        chk({nm, "_lat"}, c, 3);
        chk({nm, "_dx"}, longint'(out_dx), edx);
        chk({nm, "_dy"}, longint'(out_dy), edy);
        chk({nm, "_tag"}, longint'(out_tag), longint'(tg));
        @(posedge Clk); #1;
    endtask

    // Single request on the wide-parameter unit.
    task automatic send_w(input string nm, input int ang, input int spd, input int tg,
                          input longint edx, input longint edy);
        int c;
        w_req_valid = 1'b1;
        w_req_angle = 8'(ang);
        w_req_speed = 4'(spd);
        w_req_tag   = 2'(tg);
        #1;
        @(posedge Clk); #1;
        w_req_valid = 1'b0;
        c = 1;
        while (!w_out_valid && c < 10) begin
            @(posedge Clk); #1;
            c++;
        end
        chk({nm, "_lat"}, c, 3);
        chk({nm, "_dx"}, longint'(w_out_dx), edx);
        chk({nm, "_dy"}, longint'(w_out_dy), edy);
        chk({nm, "_tag"}, longint'(w_out_tag), longint'(tg));
        @(posedge Clk); #1;
    endtask

    // 64 angles x speeds {1,15}, back-to-back, optionally with random stalls.
    task automatic run_sweep(input bit rnd);
        longint q_dx[$];
        longint q_dy[$];
        int     q_tag[$];
        int     sent = 0, got = 0, cyc = 0, first_out = -1, last_out = -1;
        bit     held = 1'b0;
        longint h_dx = 0, h_dy = 0, h_tag = 0;
        longint edx, edy;
        while ((got < 128) && (cyc < 3000)) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < 128) begin
                req_valid = 1'b1;
                req_angle = 6'(sent % 64);
                req_speed = (sent < 64) ? 4'd1 : 4'd15;
                req_tag   = 2'(sent % 4);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            chk("ready_rule", longint'(req_ready), longint'(!(out_valid && !out_ready)));
            if (held) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_dx", longint'(out_dx), h_dx);
                chk("hold_dy", longint'(out_dy), h_dy);
                chk("hold_tag", longint'(out_tag), h_tag);
            end
            held = 1'b0;
            if (req_valid && req_ready) begin
                model(64, 8, sent % 64, (sent < 64) ? 1 : 15, edx, edy);
                q_dx.push_back(edx);
                q_dy.push_back(edy);
                q_tag.push_back(sent % 4);
                sent++;
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (q_dx.size() == 0) begin
                        chk("sb_nonempty", longint'(q_dx.size()), 1);
                    end else begin
                        chk("sweep_dx", longint'(out_dx), q_dx.pop_front());
                        chk("sweep_dy", longint'(out_dy), q_dy.pop_front());
                        chk("sweep_tag", longint'(out_tag), longint'(q_tag.pop_front()));
                    end
                    got++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end else begin
                    held  = 1'b1;
                    h_dx  = longint'(out_dx);
                    h_dy  = longint'(out_dy);
                    h_tag = longint'(out_tag);
                end
            end
            @(posedge Clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        chk("count_in", sent, 128);
        chk("count_out", got, 128);
        if (!rnd) begin
            chk("sweep_first_lat", first_out, 3);
            chk("sweep_thruput", last_out - first_out + 1, 128);
        end
    endtask

    initial begin
        longint edx, edy;
        int stale;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ready", longint'(req_ready), 0);
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_dx", longint'(out_dx), 0);
        chk("rst_dy", longint'(out_dy), 0);
        chk("rst_tag", longint'(out_tag), 0);
        chk("rst_w_valid", longint'(w_out_valid), 0);
        Reset_n = 1'b1;

        // Cardinal angles
        send_one("card0", 0, 1, 0, 256, 0);
        send_one("card16", 16, 1, 1, 0, 256);
        send_one("card32", 32, 1, 2, -256, 0);
        send_one("card48", 48, 1, 3, 0, -256);

        // 45-degree family
        send_one("a8s15", 8, 15, 1, 2715, 2715);
        send_one("a40s2", 40, 2, 2, -362, -362);
        send_one("a24s1", 24, 1, 3, -181, 181);
        send_one("a8s0", 8, 0, 0, 0, 0);

        // Sweeps
        run_sweep(1'b0);
        repeat (4) @(posedge Clk);
        #1;
        run_sweep(1'b1);
        repeat (4) @(posedge Clk);
        #1;

        // Reset with three requests in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_angle = 6'(8 * i + 1);
            req_speed = 4'd7;
            req_tag   = 2'(i);
            @(posedge Clk); #1;
        end
        req_valid = 1'b0;
        Reset_n   = 1'b0;
        #1;
        chk("mid_rst_ready", longint'(req_ready), 0);
        @(posedge Clk); #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_dx", longint'(out_dx), 0);
        chk("mid_rst_dy", longint'(out_dy), 0);
        chk("mid_rst_tag", longint'(out_tag), 0);
        Reset_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (out_valid) stale++;
        end
        chk("no_stale", stale, 0);
        model(64, 8, 5, 3, edx, edy);
        send_one("post_rst", 5, 3, 1, edx, edy);

        // Wide parameter set
        send_w("w64", 64, 15, 1, 0, 15360);
        send_w("w192", 192, 1, 2, 0, -1024);
        send_w("w255", 255, 1, 3, 1024, -25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
